// File: rtl/nib_track_ctrl.sv
// nib_track_ctrl: moves 13-sector NIB tracks between the SD image (hps_io
// block interface) and the on-chip track buffer. A modified track is written
// back before the next track is loaded, and the CPU is held while the
// buffer is being refilled.
module nib_track_ctrl #(
    parameter int SECTORS = 13,
    parameter int TRACK_W = 6,
    parameter int LBA_W   = 32
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic [TRACK_W-1:0] track,
    input  logic               dirty_set,
    input  logic               img_mounted,
    input  logic               img_present,
    input  logic               img_readonly,
    output logic [LBA_W-1:0]   sd_lba,
    output logic               sd_rd,
    output logic               sd_wr,
    input  logic               sd_ack,
    output logic [3:0]         track_sec,
    output logic               cpu_wait,
    output logic               busy,
    output logic               dirty
);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        LOAD
    } state_t;

    localparam logic [LBA_W-1:0] SECT_LBA = LBA_W'(SECTORS);
    localparam logic [3:0]       LAST_SEC = 4'(SECTORS - 1);

    state_t             state, state_nxt;
    logic [LBA_W-1:0]   sd_lba_nxt;
    logic               sd_rd_nxt, sd_wr_nxt;
    logic [3:0]         track_sec_nxt;
    logic               cpu_wait_nxt;
    logic               dirty_nxt;
    logic               valid, valid_nxt;
    logic [TRACK_W-1:0] cur_track, cur_track_nxt;
    logic               mount_pend, mount_pend_nxt;
    logic               old_ack;
    logic               ack_rise, ack_fall;
    logic [LBA_W-1:0]   base_new, base_cur;

    // sd_ack is a level held for one whole sector; its edges pace the transfer.
    assign ack_rise = sd_ack & ~old_ack;
    assign ack_fall = ~sd_ack & old_ack;

    // First sector of a track; the multiplier is a constant so this is one cycle.
    assign base_new = SECT_LBA * LBA_W'(track);
    assign base_cur = SECT_LBA * LBA_W'(cur_track);

    assign busy = (state != IDLE);

    // State and datapath registers; reset drops any request in flight at once.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state      <= IDLE;
            sd_lba     <= '0;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            track_sec  <= '0;
            cpu_wait   <= 1'b0;
            dirty      <= 1'b0;
            valid      <= 1'b0;
            cur_track  <= '0;
            mount_pend <= 1'b0;
            old_ack    <= 1'b0;
        end else begin
            state      <= state_nxt;
            sd_lba     <= sd_lba_nxt;
            sd_rd      <= sd_rd_nxt;
            sd_wr      <= sd_wr_nxt;
            track_sec  <= track_sec_nxt;
            cpu_wait   <= cpu_wait_nxt;
            dirty      <= dirty_nxt;
            valid      <= valid_nxt;
            cur_track  <= cur_track_nxt;
            mount_pend <= mount_pend_nxt;
            old_ack    <= sd_ack;
        end
    end

    // Next-state logic: IDLE decides between mount handling, write-back and
    // load; FLUSH and LOAD step one sector per sd_ack pulse.
    always_comb begin
        state_nxt      = state;
        sd_lba_nxt     = sd_lba;
        sd_rd_nxt      = sd_rd;
        sd_wr_nxt      = sd_wr;
        track_sec_nxt  = track_sec;
        cpu_wait_nxt   = cpu_wait;
        dirty_nxt      = dirty;
        valid_nxt      = valid;
        cur_track_nxt  = cur_track;
        mount_pend_nxt = mount_pend | img_mounted;

        if (dirty_set && state == IDLE && valid && img_present && !img_readonly) begin
            dirty_nxt = 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (mount_pend && !img_mounted) begin
                    // New image: the old buffer contents are simply discarded.
                    mount_pend_nxt = 1'b0;
                    dirty_nxt      = 1'b0;
                    valid_nxt      = 1'b0;
                end else if (!img_present) begin
                    valid_nxt = 1'b0;
                end else if (!valid || track != cur_track) begin
                    track_sec_nxt = '0;
                    cpu_wait_nxt  = 1'b1;
                    if (dirty) begin
                        state_nxt  = FLUSH;
                        sd_lba_nxt = base_cur;
                        sd_wr_nxt  = 1'b1;
                    end else begin
                        state_nxt     = LOAD;
                        cur_track_nxt = track;
                        sd_lba_nxt    = base_new;
                        sd_rd_nxt     = 1'b1;
                    end
                end
            end

            FLUSH: begin
                if (ack_rise) begin
                    sd_lba_nxt = sd_lba + 1'b1;
                    if (track_sec == LAST_SEC) begin
                        sd_wr_nxt = 1'b0;
                    end
                end else if (ack_fall) begin
                    if (!sd_wr) begin
                        dirty_nxt     = 1'b0;
                        state_nxt     = LOAD;
                        cur_track_nxt = track;
                        sd_lba_nxt    = base_new;
                        track_sec_nxt = '0;
                        sd_rd_nxt     = 1'b1;
                    end else begin
                        track_sec_nxt = track_sec + 1'b1;
                    end
                end
            end

            LOAD: begin
                if (ack_rise) begin
                    sd_lba_nxt = sd_lba + 1'b1;
                    if (track_sec == LAST_SEC) begin
                        sd_rd_nxt = 1'b0;
                    end
                end else if (ack_fall) begin
                    cpu_wait_nxt = 1'b0;
                    if (!sd_rd) begin
                        valid_nxt = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        track_sec_nxt = track_sec + 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: doc/nib_track_ctrl.md
Name: nib_track_ctrl

Overview:
- Sequences transfers between the SD image (hps_io block interface) and the on-chip 13-sector NIB track buffer.
- Loads a track when the drive head moves, and writes a modified track back to the image before loading a new one.
- Holds the CPU (cpu_wait) while the buffer is being refilled.
- Sits between the disk-drive emulation (track, dirty strobe) and hps_io (sd_lba/sd_rd/sd_wr/sd_ack).

Parameters:
SECTORS, 13, 512-byte SD sectors per NIB track (6656 bytes)
TRACK_W, 6, width of track number
LBA_W, 32, width of sd_lba

Ports:
clk_sys  in  1  system clock; all logic on rising edge
reset_n  in  1  synchronous active-low reset
track  in  TRACK_W  current head track from drive emulation
dirty_set  in  1  one-cycle pulse: CPU wrote into the track buffer
img_mounted  in  1  hps_io mount strobe (may be high several cycles)
img_present  in  1  image size non-zero
img_readonly  in  1  image is write-protected; suppresses write-back
sd_lba  out  LBA_W  sector address to hps_io
sd_rd  out  1  read request
sd_wr  out  1  write request
sd_ack  in  1  hps_io sector acknowledge (high for the duration of one sector)
track_sec  out  4  sector index within buffer; upper buffer address bits for both directions
cpu_wait  out  1  stall CPU
busy  out  1  transfer in progress (state != IDLE)
dirty  out  1  buffer differs from image

Behaviour:
- Reset (reset_n=0 at a clock edge): state=IDLE, sd_rd=sd_wr=0, sd_lba=0, track_sec=0, cpu_wait=0, busy=0, dirty=0, valid=0, cur_track=0, mount_pend=0, old_ack=0. Reset mid-transfer drops the request immediately. The buffer is treated as invalid.
- old_ack registers sd_ack every cycle. ack_rise = sd_ack & ~old_ack; ack_fall = ~sd_ack & old_ack.
- mount_pend is set on any cycle with img_mounted=1. It is consumed in IDLE only once img_mounted=0.
- dirty is set by dirty_set only when state=IDLE, valid=1, img_present=1 and img_readonly=0; it is ignored otherwise. dirty is cleared on FLUSH completion, on mount consumption, and on reset.
- Base LBA = SECTORS * track_number, truncated to LBA_W. The product is computed in a single cycle; the multiplier is constant.

States:
- IDLE:
  - Priority 1: if mount_pend & ~img_mounted, clear mount_pend, dirty and valid, then stay in IDLE. This discards any write-back of the old image.
  - Priority 2: if img_present and (~valid or track != cur_track):
    - if dirty, go to FLUSH with sd_lba = SECTORS*cur_track, sd_wr=1.
    - otherwise go to LOAD with cur_track <= track, sd_lba = SECTORS*track, sd_rd=1.
    - In both cases: track_sec=0, cpu_wait=1, busy=1.
  - If img_present=0, remain in IDLE with valid=0.
- FLUSH:
  - On ack_rise: sd_lba += 1; if track_sec == SECTORS-1, sd_wr <= 0.
  - On ack_fall: if sd_wr=0 (last sector), clear dirty, then go to LOAD with cur_track <= track, sd_lba = SECTORS*track, track_sec=0, sd_rd=1. Otherwise track_sec += 1.
  - cpu_wait stays 1 throughout FLUSH.
- LOAD:
  - On ack_rise: sd_lba += 1; if track_sec == SECTORS-1, sd_rd <= 0.
  - On ack_fall: cpu_wait <= 0 (the CPU resumes after the first sector); if sd_rd=0, set valid=1 and go to IDLE; otherwise track_sec += 1.
- The track input is sampled only on entry to LOAD. A track change during FLUSH or LOAD is serviced by IDLE on the cycle after return.
- A mount strobe during FLUSH or LOAD does not abort the transfer. It is consumed in IDLE, which invalidates the buffer and triggers a fresh load.
- sd_rd and sd_wr are never both 1. Each is held high continuously from the first sector until ack_rise of the last sector.
- track_sec never exceeds SECTORS-1.
- Zero-latency rule: the request asserts on the cycle after the IDLE decision.

Test Plan:
- Reset, then img_present=1, track=0 → sd_rd rises 1 cycle later with sd_lba=0. Drive 13 ack pulses → track_sec steps 0..12, sd_lba ends at 13, sd_rd drops at the 13th ack rise, cpu_wait=1 until the first ack fall, busy=0 and valid after the 13th fall.
- Loaded track 0, clean; set track=35 → load only, no sd_wr, sd_lba starts at 455.
- Loaded track 3, dirty_set pulse; set track=4 → sd_wr with sd_lba=39..51 for 13 sectors, then sd_rd with sd_lba=52, cpu_wait held high through the flush and the first load sector, dirty=0 after the flush.
- img_readonly=1, dirty_set pulse → dirty stays 0; a track change produces a load only.
- Mount strobe mid-LOAD of track 5 → the load completes. IDLE then reloads track 5 from LBA 65, and a pending dirty is cleared without any sd_wr.
- reset_n=0 during FLUSH sector 6 → sd_wr=0, cpu_wait=0, dirty=0 next cycle. After release with img_present=1, a fresh LOAD of the current track begins.
